// File: rtl/conv_reader_pkg.sv
// -----------------------------------------------------------------------------
// conv_reader_pkg
// Shared types and constants for the convolution result reader.
//   reader_state_t   : reader FSM state encoding
//   RESULT_ADDR_W    : result-memory address width used by the conv datapath
//   RESULT_DATA_W    : result word width used by the conv datapath
//   PKG_NUM_FILTERS  : filters per convolution run
//   DEFAULT_WORDS    : words read when the requested count is zero
//   words_for()      : default word count for a given filter count
// -----------------------------------------------------------------------------
package conv_reader_pkg;

    localparam int RESULT_ADDR_W   = 8;
    localparam int RESULT_DATA_W   = 32;
    localparam int PKG_NUM_FILTERS = 4;
    localparam int WORDS_PER_FILT  = 16;
    localparam int DEFAULT_WORDS   = PKG_NUM_FILTERS * WORDS_PER_FILT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_t;

    function automatic int words_for(input int num_filters);
        return num_filters * WORDS_PER_FILT;
    endfunction

endpackage

// File: rtl/conv_result_reader_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Synchronous FIFO holding {last, data} entries between the result memory
// and the output stream. Reset clears pointers and count only; storage is
// left as-is (read side must qualify data with o_empty).
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push/i_wdata : write one entry (dropped if full and not popping)
//   i_pop          : consume the head entry (ignored if empty)
//   o_rdata        : head entry, combinationally from storage
//   o_count        : current number of entries
//   o_full/o_empty : occupancy flags
// -----------------------------------------------------------------------------
module result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is accepted when the head leaves the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/conv_result_reader.sv
// -----------------------------------------------------------------------------
// conv_result_reader
// Drains the convolution result memory after a run: on start, reads
// num_words words from base_adr upward (address wraps), streams them out on
// a valid/ready interface with out_last on the final word, then pulses done.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : one-cycle start, only honoured in IDLE
//   base_adr, num_words : run parameters captured on start (0 words -> default)
//   mem_en, mem_adr     : result-memory read request
//   mem_rdata           : read data, valid one cycle after mem_en
//   out_data/out_valid/out_ready/out_last : output stream
//   busy                : run in progress (READ or DRAIN)
//   done                : one-cycle pulse after the final transfer
// Build option: define RESULT_RELU_EN to clamp negative words to zero as
// they enter the FIFO; otherwise words pass through unchanged.
// -----------------------------------------------------------------------------
module conv_result_reader
    import conv_reader_pkg::*;
#(
    parameter int ADDR_W      = RESULT_ADDR_W,
    parameter int DATA_W      = RESULT_DATA_W,
    parameter int FIFO_DEPTH  = 2,
    parameter int NUM_FILTERS = PKG_NUM_FILTERS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_adr,
    input  logic [ADDR_W-1:0] num_words,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_adr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int RUN_WORDS = words_for(NUM_FILTERS);
    // Remaining-word counter must hold both the widest num_words and the default.
    localparam int CNT_W     = (RUN_WORDS > (2**ADDR_W - 1)) ? $clog2(RUN_WORDS + 1) : ADDR_W;
    localparam int FCNT_W    = $clog2(FIFO_DEPTH + 1);

    reader_state_t     r_state;
    logic [ADDR_W-1:0] r_adr;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_inflight;
    logic              r_inflight_last;

    logic [DATA_W-1:0] w_word;
    logic [DATA_W:0]   w_fifo_rdata;
    logic [FCNT_W-1:0] w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    logic [FCNT_W:0]   w_occupancy;
    logic              w_room;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_drained;

    // FIFO entries plus the read still in flight, less the word leaving now.
    assign w_occupancy  = {1'b0, w_fifo_count} + (FCNT_W + 1)'(r_inflight)
                        - (FCNT_W + 1)'(w_pop);
    assign w_room       = w_fifo_full ? (w_pop && !r_inflight)
                                      : (w_occupancy < (FCNT_W + 1)'(FIFO_DEPTH));
    assign w_issue      = (r_state == READ) && (r_remaining != '0) && w_room;
    assign w_last_issue = w_issue && (r_remaining == CNT_W'(1));
    assign w_pop        = !w_fifo_empty && out_ready;
    // Nothing left after this cycle: no read in flight and the FIFO empties now.
    assign w_drained    = !r_inflight &&
                          ((w_fifo_count == '0) || ((w_fifo_count == FCNT_W'(1)) && w_pop));

`ifdef RESULT_RELU_EN
    assign w_word = mem_rdata[DATA_W-1] ? '0 : mem_rdata;
`else
    assign w_word = mem_rdata;
`endif

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (r_inflight),
        .i_wdata ({r_inflight_last, w_word}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_adr           <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_last_issue;
            if (w_issue) begin
                r_adr       <= r_adr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_adr       <= base_adr;
                        r_remaining <= (num_words == '0) ? CNT_W'(RUN_WORDS)
                                                         : CNT_W'(num_words);
                        r_state     <= READ;
                    end
                end
                READ: begin
                    if (w_last_issue) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = w_issue;
    assign mem_adr   = r_adr;
    assign out_valid = !w_fifo_empty;
    // FIFO storage is not reset, so data and last are forced low while empty.
    assign out_data  = out_valid ? w_fifo_rdata[DATA_W-1:0] : '0;
    assign out_last  = out_valid && w_fifo_rdata[DATA_W];
    assign busy      = (r_state == READ) || (r_state == DRAIN);
    assign done      = (r_state == DONE);

endmodule
